// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS control FSM; optional DIV funct under `DIV_OP_EN
module multicycle_control_fsm #(
    parameter int ST_W    = 4,
    parameter int ACTRL_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [5:0]         i_opcode,
    input  logic [5:0]         i_funct,
    input  logic               i_zero,
    output logic               o_iord,
    output logic               o_memwrite,
    output logic               o_irwrite,
    output logic               o_regdst,
    output logic               o_memtoreg,
    output logic               o_regwrite,
    output logic               o_alusrca,
    output logic [1:0]         o_alusrcb,
    output logic [1:0]         o_pcsrc,
    output logic               o_pcen,
    output logic [ACTRL_W-1:0] o_alucontrol,
    output logic               o_illegal
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [ACTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ACTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ACTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ACTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ACTRL_W-1:0] ALU_SLT = 4'b0111;
`ifdef DIV_OP_EN
    localparam logic [ACTRL_W-1:0] ALU_DIV = 4'b1010;
`endif

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_pcwrite;
    logic                 w_branch;
    logic                 w_funct_ok;
    logic [ACTRL_W-1:0]   w_rctrl;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_funct_ok = 1'b1;
        w_rctrl    = ALU_ADD;
        case (i_funct)
            6'b100000: w_rctrl = ALU_ADD;
            6'b100010: w_rctrl = ALU_SUB;
            6'b100100: w_rctrl = ALU_AND;
            6'b100101: w_rctrl = ALU_OR;
            6'b101010: w_rctrl = ALU_SLT;
`ifdef DIV_OP_EN
            6'b011010: w_rctrl = ALU_DIV;
`endif
            default: begin
                w_funct_ok = 1'b0;
                w_rctrl    = '0;
            end
        endcase
    end

    always_comb begin
        w_state_next = S_FETCH;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        o_iord       = 1'b0;
        o_memwrite   = 1'b0;
        o_irwrite    = 1'b0;
        o_regdst     = 1'b0;
        o_memtoreg   = 1'b0;
        o_regwrite   = 1'b0;
        o_alusrca    = 1'b0;
        o_alusrcb    = 2'b00;
        o_pcsrc      = 2'b00;
        o_pcen       = 1'b0;
        o_alucontrol = '0;
        o_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                o_alusrcb    = 2'b01;
                o_alucontrol = ALU_ADD;
                o_irwrite    = 1'b1;
                w_pcwrite    = 1'b1;
                w_state_next = S_DECODE;
            end
            S_DECODE: begin
                o_alusrcb    = 2'b11;
                o_alucontrol = ALU_ADD;
                case (i_opcode)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_BEQ:       w_state_next = S_BEQEX;
                    OP_ADDI:      w_state_next = S_ADDIEX;
                    OP_J:         w_state_next = S_JEX;
                    OP_R: begin
                        if (w_funct_ok) w_state_next = S_RTYPEEX;
                        else            o_illegal    = 1'b1;
                    end
                    default:      o_illegal    = 1'b1;
                endcase
            end
            S_MEMADR: begin
                o_alusrca    = 1'b1;
                o_alusrcb    = 2'b10;
                o_alucontrol = ALU_ADD;
                if (i_opcode == OP_LW)      w_state_next = S_MEMRD;
                else if (i_opcode == OP_SW) w_state_next = S_MEMWR;
            end
            S_MEMRD: begin
                o_iord       = 1'b1;
                w_state_next = S_MEMWB;
            end
            S_MEMWB: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
            end
            S_MEMWR: begin
                o_iord     = 1'b1;
                o_memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                o_alusrca    = 1'b1;
                o_alucontrol = w_rctrl;
                w_state_next = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
            end
            S_BEQEX: begin
                o_alusrca    = 1'b1;
                o_alucontrol = ALU_SUB;
                o_pcsrc      = 2'b01;
                w_branch     = 1'b1;
            end
            S_ADDIEX: begin
                o_alusrca    = 1'b1;
                o_alusrcb    = 2'b10;
                o_alucontrol = ALU_ADD;
                w_state_next = S_ADDIWB;
            end
            S_ADDIWB: o_regwrite = 1'b1;
            S_JEX: begin
                o_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_state_next = S_FETCH;
        endcase

        o_pcen = w_pcwrite | (w_branch & i_zero);

        // While reset is held the datapath must see no writes and no pulses.
        if (i_reset) begin
            o_iord       = 1'b0;
            o_memwrite   = 1'b0;
            o_irwrite    = 1'b0;
            o_regdst     = 1'b0;
            o_memtoreg   = 1'b0;
            o_regwrite   = 1'b0;
            o_alusrca    = 1'b0;
            o_alusrcb    = 2'b00;
            o_pcsrc      = 2'b00;
            o_pcen       = 1'b0;
            o_alucontrol = '0;
            o_illegal    = 1'b0;
        end
    end

endmodule
